// File: rtl/mlaccel_smem.sv
// mlaccel_smem: dual-port (host + fetch) sequencer instruction memory.
// Two 16-bit banks (even/odd halfwords) give 32-bit access at any halfword.
//
// Ports:
//   clock, resetn            rising-edge clock, synchronous active-low reset
//   smem_valid/smem_ready    fetch handshake; smem_addr in, smem_data out
//   host_valid/host_ready    host handshake; host_write selects write/read
//   host_addr, host_wdata    host halfword address and write data
//   host_rdata               host read data, valid while host_ready
//
// Build option: MLACCEL_SMEM_SEQPRIO_EN gives the fetch port fixed priority;
// otherwise the two ports are arbitrated round-robin.
module mlaccel_smem #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        smem_valid,
  output logic        smem_ready,
  input  logic [15:0] smem_addr,
  output logic [31:0] smem_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_write,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata
);

  localparam int IW = ADDR_BITS - 1;
  localparam int DEPTH = 1 << IW;

  typedef enum logic {
    IDLE,
    RESP
  } port_state_e;

  port_state_e s_state, s_next;
  port_state_e h_state, h_next;

  logic s_elig, h_elig;
  logic grant_s, grant_h;

  logic [15:0] even_bank [DEPTH];
  logic [15:0] odd_bank  [DEPTH];

  logic [ADDR_BITS-1:0] a;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        ev_idx;
  logic                 a_odd;
  logic [31:0]          rd;
  logic [15:0]          ev_w, od_w;
  logic                 wr_en;

`ifndef MLACCEL_SMEM_SEQPRIO_EN
  logic last_host;
`endif

  always_comb begin
    s_elig = smem_valid && (s_state == IDLE);
    h_elig = host_valid && (h_state == IDLE);
`ifdef MLACCEL_SMEM_SEQPRIO_EN
    grant_s = s_elig;
`else
    grant_s = s_elig && (!h_elig || last_host);
`endif
    grant_h = h_elig && !grant_s;
  end

  always_comb begin
    s_next = s_state;
    h_next = h_state;
    unique case (s_state)
      IDLE: if (grant_s) s_next = RESP;
      RESP: s_next = IDLE;
    endcase
    unique case (h_state)
      IDLE: if (grant_h) h_next = RESP;
      RESP: h_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s_state <= IDLE;
      h_state <= IDLE;
    end else begin
      s_state <= s_next;
      h_state <= h_next;
    end
  end

  // Gated by resetn so a response pending at reset is never seen.
  assign smem_ready = resetn && (s_state == RESP);
  assign host_ready = resetn && (h_state == RESP);

  // Odd start: low half in odd[i], high half in even[i+1] (wraps).
  always_comb begin
    a = grant_s ? smem_addr[ADDR_BITS-1:0]
                : host_addr[ADDR_BITS-1:0];
    idx = a[ADDR_BITS-1:1];
    a_odd = a[0];
    ev_idx = a_odd ? idx + 1'b1 : idx;
    rd = a_odd ? {even_bank[ev_idx], odd_bank[idx]}
               : {odd_bank[idx], even_bank[ev_idx]};
    ev_w = a_odd ? host_wdata[31:16] : host_wdata[15:0];
    od_w = a_odd ? host_wdata[15:0] : host_wdata[31:16];
    wr_en = grant_h && host_write;
  end

  always_ff @(posedge clock) begin
    if (resetn && wr_en) begin
      even_bank[ev_idx] <= ev_w;
      odd_bank[idx]     <= od_w;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      smem_data  <= '0;
      host_rdata <= '0;
    end else begin
      if (grant_s) smem_data <= rd;
      if (grant_h && !host_write) host_rdata <= rd;
    end
  end

`ifndef MLACCEL_SMEM_SEQPRIO_EN
  always_ff @(posedge clock) begin
    if (!resetn) last_host <= 1'b1;
    else if (grant_s) last_host <= 1'b0;
    else if (grant_h) last_host <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mlaccel_smem.sv
// tb_mlaccel_smem: randomized bench for mlaccel_smem with a
// behavioural halfword-array model checked every cycle.
module tb_mlaccel_smem;

  logic        clock = 1'b0;
  logic        resetn;
  logic        smem_valid;
  logic        smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        host_valid;
  logic        host_ready;
  logic        host_write;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;

  always #5 clock = ~clock;

  mlaccel_smem #(.ADDR_BITS(16)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .smem_valid (smem_valid),
    .smem_ready (smem_ready),
    .smem_addr  (smem_addr),
    .smem_data  (smem_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_write (host_write),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: plain halfword array, known flags, expected responses.
  logic [15:0] mem [0:65535];
  bit          kn  [0:65535];
  bit          m_ok = 0;
  bit          e_sr, e_hr;
  logic [31:0] e_sd, e_hd;
  bit          e_sd_k, e_hd_k;
  bit          m_last_host;
  bit          prev_sr, prev_hr;

  function automatic logic [15:0] f(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  task automatic m_read(input logic [15:0] a, output logic [31:0] d,
                        output bit k);
    logic [15:0] a1;
    a1 = a + 16'd1;
    d = {mem[a1], mem[a]};
    k = kn[a] && kn[a1];
  endtask

  task automatic m_write(input logic [15:0] a, input logic [31:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    mem[a] = d[15:0];
    mem[a1] = d[31:16];
    kn[a] = 1;
    kn[a1] = 1;
  endtask

  always @(negedge clock) begin
    bit se, he, gs, gh;
    if (m_ok) begin
      chk("smem_ready", smem_ready, e_sr && resetn);
      chk("host_ready", host_ready, e_hr && resetn);
      if (e_sd_k) chk("smem_data", smem_data, e_sd);
      if (e_hd_k) chk("host_rdata", host_rdata, e_hd);
      chk("smem_ready_back2back", prev_sr && smem_ready, 0);
      chk("host_ready_back2back", prev_hr && host_ready, 0);
      prev_sr = smem_ready;
      prev_hr = host_ready;
    end
    if (!resetn) begin
      m_ok = 1;
      e_sr = 0;
      e_hr = 0;
      e_sd = 0;
      e_hd = 0;
      e_sd_k = 1;
      e_hd_k = 1;
      m_last_host = 1;
    end else if (m_ok) begin
      se = smem_valid && !e_sr;
      he = host_valid && !e_hr;
`ifdef MLACCEL_SMEM_SEQPRIO_EN
      gs = se;
`else
      gs = se && (!he || m_last_host);
`endif
      gh = he && !gs;
      e_sr = gs;
      e_hr = gh;
      if (gs) begin
        m_read(smem_addr, e_sd, e_sd_k);
        m_last_host = 0;
      end
      if (gh) begin
        m_last_host = 1;
        if (host_write) m_write(host_addr, host_wdata);
        else m_read(host_addr, e_hd, e_hd_k);
      end
    end
  end

  task automatic host_op(input bit wr, input logic [15:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output int lat);
    bit got;
    int n;
    @(posedge clock);
    #1;
    host_valid = 1;
    host_write = wr;
    host_addr = a;
    host_wdata = d;
    lat = 0;
    got = 0;
    n = 0;
    while (!got && n < 30) begin
      @(negedge clock);
      if (host_ready) got = 1;
      else lat++;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL host_timeout: got no host_ready expected ready");
    end
    rd = host_rdata;
    @(posedge clock);
    #1;
    host_valid = 0;
  endtask

  task automatic fetch_op(input logic [15:0] a, input int hold,
                          output logic [31:0] rd, output int lat);
    bit got;
    int n;
    @(posedge clock);
    #1;
    smem_valid = 1;
    smem_addr = a;
    lat = 0;
    got = 0;
    n = 0;
    while (!got && n < 30) begin
      @(negedge clock);
      if (smem_ready) got = 1;
      else lat++;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no smem_ready expected ready");
    end
    rd = smem_data;
    repeat (hold) @(posedge clock);
    @(posedge clock);
    #1;
    smem_valid = 0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] r;
    r = 16'($urandom_range(0, 127));
    return r - 16'd64;
  endfunction

  task automatic fetch_drv();
    logic [31:0] d;
    int lat;
    repeat (120) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      fetch_op(rand_addr(), $urandom_range(0, 3), d, lat);
    end
  endtask

  task automatic host_drv();
    logic [31:0] d;
    int lat;
    repeat (120) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      host_op(1'($urandom_range(0, 1)), rand_addr(), $urandom, d, lat);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat;
    logic [15:0] pa;
    resetn = 0;
    smem_valid = 0;
    smem_addr = 0;
    host_valid = 0;
    host_write = 0;
    host_addr = 0;
    host_wdata = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset smem_ready", smem_ready, 0);
    chk("reset host_ready", host_ready, 0);
    chk("reset smem_data", smem_data, 0);
    chk("reset host_rdata", host_rdata, 0);
    @(posedge clock);
    #1;
    resetn = 1;

    for (int k = 0; k < 64; k += 2) begin
      pa = 16'(k);
      host_op(1, pa, {f(pa + 16'd1), f(pa)}, d, lat);
      pa = 16'hFFC0 + 16'(k);
      host_op(1, pa, {f(pa + 16'd1), f(pa)}, d, lat);
    end

    host_op(1, 16'h0010, 32'hDEADBEEF, d, lat);
    chk("write latency", 32'(lat), 1);
    fetch_op(16'h0010, 0, d, lat);
    chk("t1 fetch latency", 32'(lat), 1);
    chk("t1 fetch data", d, 32'hDEADBEEF);

    host_op(1, 16'h0011, 32'h12345678, d, lat);
    host_op(0, 16'h0012, 32'h0, d, lat);
    chk("t2 host read", d, 32'h5A131234);
    fetch_op(16'h0010, 0, d, lat);
    chk("t2 fetch hi", {16'h0, d[31:16]}, 32'h5678);
    chk("t2 fetch lo", {16'h0, d[15:0]}, 32'hBEEF);

    host_op(1, 16'hFFFF, 32'hAAAA5555, d, lat);
    fetch_op(16'h0000, 0, d, lat);
    chk("t3 wrap fetch", d, 32'h5A01AAAA);
    host_op(0, 16'hFFFF, 32'h0, d, lat);
    chk("t3 wrap read", d, 32'hAAAA5555);

    // Both ports requesting continuously from reset release.
    @(posedge clock);
    #1;
    resetn = 0;
    smem_valid = 1;
    smem_addr = 16'h0004;
    host_valid = 1;
    host_write = 0;
    host_addr = 16'h0006;
    @(posedge clock);
    #1;
    resetn = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("arb smem_ready %0d", i), smem_ready, i % 2 == 1);
      chk($sformatf("arb host_ready %0d", i), host_ready,
          (i % 2 == 0) && (i > 0));
    end
    chk("arb smem_data", smem_data, 32'h5A055A04);
    chk("arb host_rdata", host_rdata, 32'h5A075A06);
    @(posedge clock);
    #1;
    smem_valid = 0;
    host_valid = 0;
    repeat (2) @(posedge clock);

    // Reset in the response cycle of a granted write.
    @(posedge clock);
    #1;
    host_valid = 1;
    host_write = 1;
    host_addr = 16'h0020;
    host_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    resetn = 0;
    host_valid = 0;
    @(negedge clock);
    chk("rst host_ready", host_ready, 0);
    @(posedge clock);
    #1;
    resetn = 1;
    host_op(0, 16'h0020, 32'h0, d, lat);
    chk("rst write kept", d, 32'hCAFEF00D);

    // Write presented only while reset is held must not commit.
    @(posedge clock);
    #1;
    resetn = 0;
    host_valid = 1;
    host_write = 1;
    host_addr = 16'h0030;
    host_wdata = 32'h11112222;
    repeat (2) @(posedge clock);
    #1;
    host_valid = 0;
    resetn = 1;
    host_op(0, 16'h0030, 32'h0, d, lat);
    chk("rst write blocked", d, 32'h5A315A30);

    fork
      fetch_drv();
      host_drv();
    join

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule

// File: doc/mlaccel_smem.md
# mlaccel_smem

Sequencer instruction memory with two request ports. The host port loads and reads back the program. The fetch port serves the sequencer's `smem_valid/smem_ready/smem_addr/smem_data` handshake directly. Storage is two 16-bit banks (even and odd halfwords), so any 32-bit read or write may start on any halfword address, including the odd addresses produced by call targets.

## Interface

- `ADDR_BITS`, default 16: halfword address width; each bank holds 2^(ADDR_BITS-1) entries.
- `clock`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `smem_valid`  in  1  fetch request; held with `smem_addr` stable until `smem_ready`.
- `smem_ready`  out  1  one-cycle response strobe; `smem_data` is valid in that cycle.
- `smem_addr`  in  16  halfword address of the fetch.
- `smem_data`  out  32  `{hw[a+1], hw[a]}`.
- `host_valid`  in  1  host request; held stable until `host_ready`.
- `host_ready`  out  1  one-cycle completion strobe.
- `host_write`  in  1  1 = write, 0 = read.
- `host_addr`  in  16  halfword address.
- `host_wdata`  in  32  `[15:0]` goes to hw[a], `[31:16]` goes to hw[a+1].
- `host_rdata`  out  32  read data, valid while `host_ready`.

## Operation

- Let a = address and i = a[ADDR_BITS-1:1]. Only the low ADDR_BITS of each address are used.
- Even a: lo = even[i], hi = odd[i].
- Odd a: lo = odd[i], hi = even[(i+1) mod 2^(ADDR_BITS-1)].
- The top address wraps to halfword 0. Upper address bits at or above ADDR_BITS are ignored.
- Each bank performs one access per cycle. The two banks are always accessed together, so at most one port is granted per cycle.
- Each port has a 2-state FSM:
  - IDLE → RESP on grant.
  - RESP → IDLE unconditionally.
  - In RESP, the port's ready = 1.
- A port in RESP is not eligible for grant, even if its valid is still high. This matches the sequencer, which drops valid only after seeing ready.
- Eligible port: valid = 1 and FSM in IDLE.
- Grant rules:
  - If only one port is eligible, it is granted.
  - If both are eligible, the port not granted most recently wins (round-robin).
  - `last_grant` resets to host, so the fetch port wins the first tie.
- Write:
  - Both halfwords are committed at the grant edge.
  - `host_ready` is asserted the next cycle.
  - `host_rdata` holds its previous value during a write.
- Read: bank data is registered at the grant edge and presented with ready the next cycle. `smem_data` and `host_rdata` hold their value until the port's next read.
- A read granted after a write's grant edge returns the new data. This includes a fetch granted in the cycle right after the write.

## Timing

- Request-to-ready latency:
  - 1 cycle when granted on the first valid cycle.
  - Extended by one cycle for each lost arbitration.
- Peak throughput: one transfer per 2 cycles per port. With both ports active, the memory is busy every cycle.
- Reset values: `smem_ready` = 0, `host_ready` = 0, `smem_data` = 0, `host_rdata` = 0, both FSMs IDLE, `last_grant` = host. Bank contents are not reset.
- Reset mid-operation:
  - A pending RESP is discarded and no ready is issued.
  - No write commits on any edge where `resetn` = 0.
- Valid dropped before ready (sequencer `start`/`reset` abandon):
  - A request not yet granted is simply forgotten.
  - A request already granted still completes with ready. The requester ignores it.
- Simultaneous host write and fetch to overlapping halfwords: the arbitration order decides, and the fetch sees either all-old or all-new data, never a mix.

## Configuration

- `MLACCEL_SMEM_SEQPRIO_EN` defined: fixed priority. The fetch port always wins when both are eligible, and `last_grant` is not implemented. The host is still served in every cycle the fetch port is in RESP or idle.
- Not defined: round-robin as above.

## Test plan

- Host write at 0x0010 with 0xDEADBEEF, then fetch at 0x0010 → `smem_ready` 1 cycle after fetch valid, `smem_data` = 0xDEADBEEF.
- Host write at 0x0011 with 0x12345678, then host read at 0x0012 → `host_rdata[15:0]` = 0x1234, `[31:16]` = the previous hw[0x0013]. Fetch at 0x0010 → `smem_data[31:16]` = 0x5678.
- Host write at 0xFFFF with 0xAAAA5555 → hw[0xFFFF] = 0x5555 and hw[0x0000] = 0xAAAA. A fetch at 0x0000 returns low half 0xAAAA.
- Both ports valid continuously from reset release:
  - Without the macro: grants alternate fetch, host, fetch, …, and each ready is 1 cycle wide.
  - With `MLACCEL_SMEM_SEQPRIO_EN`: the host is granted only in cycles when the fetch FSM is in RESP.
- `smem_valid` held high for 3 cycles after ready with no new address → exactly one `smem_ready` pulse per grant, never on two consecutive cycles.
- `resetn` low in the cycle after a host write is granted → no `host_ready`. Memory reflects the write, because the commit edge preceded reset. A write whose grant edge has `resetn` = 0 leaves memory unchanged.
